// File: rtl/secure_lsu_if.sv
// rtl/secure_lsu_if.sv - core request/response, key-write and memory bus bundle for secure_lsu
interface secure_lsu_if #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int NUM_REGIONS = 4,
  parameter int MAX_FAULTS  = 3
);
  localparam int RW  = $clog2(NUM_REGIONS);
  localparam int FCW = $clog2(MAX_FAULTS + 1);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_key;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_fault;
  logic              key_we;
  logic [RW-1:0]     key_region;
  logic [DATA_W-1:0] key_wdata;
  logic              mem_valid;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              locked;
  logic [FCW-1:0]    fault_count;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_key,
    input  key_we, key_region, key_wdata,
    input  mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_valid, mem_write, mem_addr, mem_wdata,
    output locked, fault_count
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_key,
    output key_we, key_region, key_wdata,
    output mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_valid, mem_write, mem_addr, mem_wdata,
    input  locked, fault_count
  );
endinterface

// File: rtl/secure_lsu.sv
// rtl/secure_lsu.sv - keyed, XOR-encrypting multi-cycle load/store unit with fault lockout
// Optional key rotation by word address: define SECURE_LSU_ROTATE_EN.
module secure_lsu #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int NUM_REGIONS = 4,
  parameter int MAX_FAULTS  = 3,
  parameter int TIMEOUT     = 16
) (
  input logic         clk,
  input logic         reset,
  secure_lsu_if.slave bus
);
  localparam int RW  = $clog2(NUM_REGIONS);
  localparam int FCW = $clog2(MAX_FAULTS + 1);
  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MEM, S_RESP, S_LOCK} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic [FCW-1:0]    fault_cnt_q, fault_cnt_d;

  logic [DATA_W-1:0]      key_table_q [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] key_valid_q;

  logic [RW-1:0]     region;
  logic [DATA_W-1:0] key_cur;
  logic [DATA_W-1:0] eff_key;
  logic              key_match;
  logic              key_wr_en;

  assign region    = addr_q[ADDR_W-1 -: RW];
  assign key_cur   = key_table_q[region];
  assign key_match = key_valid_q[region] && (key_q == key_cur);
  assign key_wr_en = (state_q == S_IDLE) && bus.key_we;

`ifdef SECURE_LSU_ROTATE_EN
  int                  rot_amt;
  logic [2*DATA_W-1:0] key_dbl;
  assign rot_amt = int'(addr_q) % DATA_W;
  assign key_dbl = {key_cur, key_cur} << rot_amt;
  assign eff_key = key_dbl[2*DATA_W-1:DATA_W];
`else
  assign eff_key = key_cur;
`endif

  // The table is written at the IDLE edge, so a same-cycle accept sees the new key in CHECK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) key_table_q[i] <= '0;
      key_valid_q <= '0;
    end else if (key_wr_en) begin
      key_table_q[bus.key_region] <= bus.key_wdata;
      key_valid_q[bus.key_region] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      key_q       <= '0;
      write_q     <= 1'b0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      wait_q      <= '0;
      fault_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      key_q       <= key_d;
      write_q     <= write_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      wait_q      <= wait_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    key_d       = key_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    wait_d      = wait_q;
    fault_cnt_d = fault_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          key_d   = bus.req_key;
          write_d = bus.req_write;
          rdata_d = '0;
          fault_d = 1'b0;
          wait_d  = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (key_match) begin
          state_d = S_MEM;
        end else begin
          fault_d = 1'b1;
          state_d = S_RESP;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (!write_q) rdata_d = bus.mem_rdata ^ eff_key;
          state_d = S_RESP;
        end else if (wait_q == WCW'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = S_RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RESP: begin
        if (fault_q && (fault_cnt_q != FCW'(MAX_FAULTS))) fault_cnt_d = fault_cnt_q + 1'b1;
        state_d = (fault_cnt_d == FCW'(MAX_FAULTS)) ? S_LOCK : S_IDLE;
      end
      S_LOCK: state_d = S_LOCK;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the state register so reset deasserts mem_valid without waiting for an edge.
  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.resp_valid  = (state_q == S_RESP);
  assign bus.resp_fault  = (state_q == S_RESP) && fault_q;
  assign bus.resp_rdata  = ((state_q == S_RESP) && !fault_q) ? rdata_q : '0;
  assign bus.mem_valid   = (state_q == S_MEM);
  assign bus.mem_write   = (state_q == S_MEM) && write_q;
  assign bus.mem_addr    = (state_q == S_MEM) ? addr_q : '0;
  assign bus.mem_wdata   = (state_q == S_MEM) ? (wdata_q ^ eff_key) : '0;
  assign bus.locked      = (state_q == S_LOCK);
  assign bus.fault_count = fault_cnt_q;
endmodule
